// File: rtl/switch_allocator_rr_if.sv
// Handshake bundle between input buffers/route calculators, the switch allocator
// and the crossbar of one mesh router.
interface switch_allocator_rr_if #(
    parameter int N  = 5,
    parameter int SW = $clog2(N)
);
    logic [0:N-1]          i_val;
    logic [0:N-1]          i_head;
    logic [0:N-1]          i_tail;
    logic [0:N-1][0:N-1]   i_output_req;
    logic [0:N-1]          i_out_ready;
    logic [0:N-1]          o_in_ack;
    logic [0:N-1]          o_out_val;
    logic [0:N-1][SW-1:0]  o_sel;
    logic [0:N-1]          o_locked;

    modport master (
        output i_val, i_head, i_tail, i_output_req, i_out_ready,
        input  o_in_ack, o_out_val, o_sel, o_locked
    );

    modport slave (
        input  i_val, i_head, i_tail, i_output_req, i_out_ready,
        output o_in_ack, o_out_val, o_sel, o_locked
    );
endinterface

// File: rtl/switch_allocator_rr.sv
// Wormhole switch allocator: per-output round-robin arbitration on head flits,
// with the grant held from head to tail and driving crossbar select / input ack.
module switch_allocator_rr #(
    parameter int N  = 5,
    parameter int SW = $clog2(N)
) (
    input  logic i_clk,
    input  logic i_reset,
    switch_allocator_rr_if.slave bus
);

    logic [0:N-1]         lock_q, lock_d;
    logic [0:N-1][SW-1:0] owner_q, owner_d;
    logic [0:N-1][SW-1:0] ptr_q, ptr_d;
    logic [0:N-1]         mid_pkt_q, mid_pkt_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_q    <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            mid_pkt_q <= '0;
        end else begin
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            mid_pkt_q <= mid_pkt_d;
        end
    end

    always_comb begin
        logic          found;
        logic [SW-1:0] win;
        int            idx;
        lock_d        = lock_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        bus.o_in_ack  = '0;
        bus.o_out_val = '0;
        bus.o_sel     = '0;
        found         = 1'b0;
        win           = '0;
        idx           = 0;
        for (int j = 0; j < N; j++) begin
            found = 1'b0;
            win   = '0;
            if (lock_q[j]) begin
                bus.o_sel[j] = owner_q[j];
                if (bus.i_val[owner_q[j]] && bus.i_out_ready[j]) begin
                    bus.o_out_val[j]          = 1'b1;
                    bus.o_in_ack[owner_q[j]]  = 1'b1;
                    if (bus.i_tail[owner_q[j]]) begin
                        lock_d[j] = 1'b0;
                    end
                end
            end else begin
                // Scan from the priority pointer, wrapping at N rather than 2^SW.
                for (int k = 0; k < N; k++) begin
                    idx = int'(ptr_q[j]) + k;
                    if (idx >= N) begin
                        idx = idx - N;
                    end
                    if (!found && bus.i_val[idx] && bus.i_head[idx] && bus.i_output_req[idx][j]) begin
                        found = 1'b1;
                        win   = SW'(idx);
                    end
                end
                if (found) begin
                    lock_d[j]  = 1'b1;
                    owner_d[j] = win;
                    ptr_d[j]   = (win == SW'(N - 1)) ? '0 : win + SW'(1);
                end
            end
        end
    end

    // Tracks inputs that have sent a head but not yet their tail.
    always_comb begin
        mid_pkt_d = mid_pkt_q;
        for (int i = 0; i < N; i++) begin
            if (bus.o_in_ack[i]) begin
                mid_pkt_d[i] = ~bus.i_tail[i];
            end
        end
    end

    assign bus.o_locked = lock_q;

    for (genvar g = 0; g < N; g++) begin : g_chk
        a_onehot_req : assert property (@(posedge i_clk) disable iff (i_reset)
            bus.i_val[g] |-> $onehot0(bus.i_output_req[g]));
        a_no_head_mid_pkt : assert property (@(posedge i_clk) disable iff (i_reset)
            !(mid_pkt_q[g] && bus.i_val[g] && bus.i_head[g]));
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed bench for switch_allocator_rr: per-cycle expectations are queued as
// stimulus is driven and popped/compared while the cycle's outputs are stable.
module tb_switch_allocator_rr;

    localparam int N  = 5;
    localparam int SW = $clog2(N);

    typedef logic [0:N-1]         vec_t;
    typedef logic [0:N-1][0:N-1]  req_t;
    typedef logic [0:N-1][SW-1:0] sel_t;

    typedef struct packed {
        vec_t ack;
        vec_t oval;
        vec_t lock;
        sel_t sel;
    } exp_t;

    localparam vec_t Z = '0;
    localparam vec_t A = '1;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    exp_t  sb[$];
    string tag_q[$];

    switch_allocator_rr_if #(.N(N), .SW(SW)) bus ();

    switch_allocator_rr #(.N(N), .SW(SW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t oh(input int i);
        vec_t v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic req_t rq(input int d0, input int d1, input int d2, input int d3, input int d4);
        req_t r;
        r[0] = oh(d0);
        r[1] = oh(d1);
        r[2] = oh(d2);
        r[3] = oh(d3);
        r[4] = oh(d4);
        return r;
    endfunction

    function automatic sel_t sl(input int s0, input int s1, input int s2, input int s3, input int s4);
        sel_t s;
        s[0] = SW'(s0);
        s[1] = SW'(s1);
        s[2] = SW'(s2);
        s[3] = SW'(s3);
        s[4] = SW'(s4);
        return s;
    endfunction

    task automatic checkOutput();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            total_cnt++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        t = tag_q.pop_front();
        total_cnt++;
        assert (bus.o_in_ack === e.ack) pass_cnt++;
        else $error("[TB] FAIL %s o_in_ack observed=%b expected=%b", t, bus.o_in_ack, e.ack);
        total_cnt++;
        assert (bus.o_out_val === e.oval) pass_cnt++;
        else $error("[TB] FAIL %s o_out_val observed=%b expected=%b", t, bus.o_out_val, e.oval);
        total_cnt++;
        assert (bus.o_locked === e.lock) pass_cnt++;
        else $error("[TB] FAIL %s o_locked observed=%b expected=%b", t, bus.o_locked, e.lock);
        total_cnt++;
        assert (bus.o_sel === e.sel) pass_cnt++;
        else $error("[TB] FAIL %s o_sel observed=%h expected=%h", t, bus.o_sel, e.sel);
    endtask

    // One clock cycle: drive at the falling edge, queue the expected outputs for
    // this cycle, then compare while the combinational outputs are stable.
    task automatic applyStimulus(input string tag, input logic r, input vec_t val, input vec_t head,
                                 input vec_t tail, input req_t req, input vec_t rdy,
                                 input vec_t eack, input vec_t eoval, input vec_t elock, input sel_t esel);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.i_val        = val;
        bus.i_head       = head;
        bus.i_tail       = tail;
        bus.i_output_req = req;
        bus.i_out_ready  = rdy;
        e.ack  = eack;
        e.oval = eoval;
        e.lock = elock;
        e.sel  = esel;
        sb.push_back(e);
        tag_q.push_back(tag);
        #2;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   order[6];
        vec_t rrin;
        vec_t hd;
        vec_t tl;
        order = '{1, 3, 4, 1, 3, 4};
        pass_cnt  = 0;
        total_cnt = 0;
        rst              = 1'b1;
        bus.i_val        = '0;
        bus.i_head       = '0;
        bus.i_tail       = '0;
        bus.i_output_req = '0;
        bus.i_out_ready  = '1;

        // Reset, then idle
        applyStimulus("reset0", 1'b1, Z, Z, Z, '0, A, Z, Z, Z, '0);
        applyStimulus("reset1", 1'b1, Z, Z, Z, '0, A, Z, Z, Z, '0);
        for (int k = 0; k < 10; k++)
            applyStimulus("idle", 1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        // Single-flit packet local -> east
        applyStimulus("sf_arb",  1'b0, oh(0), oh(0), oh(0), rq(2, -1, -1, -1, -1), A, Z, Z, Z, '0);
        applyStimulus("sf_xfer", 1'b0, oh(0), oh(0), oh(0), rq(2, -1, -1, -1, -1), A,
                      oh(0), oh(2), oh(2), '0);
        applyStimulus("sf_rel",  1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        // Round-robin on output 0 among inputs 1, 3, 4 (exercises pointer wrap)
        rrin = oh(1) | oh(3) | oh(4);
        for (int k = 0; k < 6; k++) begin
            applyStimulus("rr_arb", 1'b0, rrin, rrin, rrin, rq(-1, 0, -1, 0, 0), A, Z, Z, Z, '0);
            applyStimulus("rr_grant", 1'b0, rrin, rrin, rrin, rq(-1, 0, -1, 0, 0), A,
                          oh(order[k]), oh(0), oh(0), sl(order[k], 0, 0, 0, 0));
        end
        applyStimulus("rr_done", 1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        // Wormhole hold: input 2 sends 4 flits to output 4, input 3 waits
        applyStimulus("wh_arb", 1'b0, oh(2) | oh(3), oh(2) | oh(3), oh(3), rq(-1, -1, 4, 4, -1), A,
                      Z, Z, Z, '0);
        for (int k = 0; k < 4; k++) begin
            hd = oh(3) | ((k == 0) ? oh(2) : Z);
            tl = oh(3) | ((k == 3) ? oh(2) : Z);
            applyStimulus("wh_hold", 1'b0, oh(2) | oh(3), hd, tl, rq(-1, -1, 4, 4, -1), A,
                          oh(2), oh(4), oh(4), sl(0, 0, 0, 0, 2));
        end
        applyStimulus("wh_arb3", 1'b0, oh(3), oh(3), oh(3), rq(-1, -1, -1, 4, -1), A, Z, Z, Z, '0);
        applyStimulus("wh_xfer3", 1'b0, oh(3), oh(3), oh(3), rq(-1, -1, -1, 4, -1), A,
                      oh(3), oh(4), oh(4), sl(0, 0, 0, 0, 3));

        // Body flit to an idle output and a request without valid are both ignored
        applyStimulus("ign_req", 1'b0, oh(0), oh(1), Z, rq(1, 1, -1, -1, -1), A, Z, Z, Z, '0);
        applyStimulus("ign_after", 1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        // Backpressure then bubble on a 3-flit packet input 3 -> output 1
        applyStimulus("bp_arb", 1'b0, oh(3), oh(3), Z, rq(-1, -1, -1, 1, -1), A, Z, Z, Z, '0);
        applyStimulus("bp_f1", 1'b0, oh(3), oh(3), Z, rq(-1, -1, -1, 1, -1), A,
                      oh(3), oh(1), oh(1), sl(0, 3, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            applyStimulus("bp_stall", 1'b0, oh(3), Z, Z, rq(-1, -1, -1, 1, -1), A & ~oh(1),
                          Z, Z, oh(1), sl(0, 3, 0, 0, 0));
        for (int k = 0; k < 2; k++)
            applyStimulus("bp_bubble", 1'b0, Z, Z, Z, '0, A, Z, Z, oh(1), sl(0, 3, 0, 0, 0));
        applyStimulus("bp_f2", 1'b0, oh(3), Z, Z, rq(-1, -1, -1, 1, -1), A,
                      oh(3), oh(1), oh(1), sl(0, 3, 0, 0, 0));
        applyStimulus("bp_f3", 1'b0, oh(3), Z, oh(3), rq(-1, -1, -1, 1, -1), A,
                      oh(3), oh(1), oh(1), sl(0, 3, 0, 0, 0));
        applyStimulus("bp_done", 1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        // Parallel allocation 0->2 and 1->3, then reset mid-packet
        applyStimulus("par_arb", 1'b0, oh(0) | oh(1), oh(0) | oh(1), Z, rq(2, 3, -1, -1, -1), A,
                      Z, Z, Z, '0);
        applyStimulus("par_f1", 1'b0, oh(0) | oh(1), oh(0) | oh(1), Z, rq(2, 3, -1, -1, -1), A,
                      oh(0) | oh(1), oh(2) | oh(3), oh(2) | oh(3), sl(0, 0, 0, 1, 0));
        applyStimulus("par_f2", 1'b0, oh(0) | oh(1), Z, Z, rq(2, 3, -1, -1, -1), A,
                      oh(0) | oh(1), oh(2) | oh(3), oh(2) | oh(3), sl(0, 0, 0, 1, 0));
        applyStimulus("par_rst", 1'b1, oh(0) | oh(1), Z, Z, rq(2, 3, -1, -1, -1), A,
                      oh(0) | oh(1), oh(2) | oh(3), oh(2) | oh(3), sl(0, 0, 0, 1, 0));
        applyStimulus("post_rst", 1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        // Pointer of output 3 is back at 0: input 1 beats input 4
        applyStimulus("ptr_arb", 1'b0, oh(1) | oh(4), oh(1) | oh(4), oh(1) | oh(4), rq(-1, 3, -1, -1, 3), A,
                      Z, Z, Z, '0);
        applyStimulus("ptr_g1", 1'b0, oh(1) | oh(4), oh(1) | oh(4), oh(1) | oh(4), rq(-1, 3, -1, -1, 3), A,
                      oh(1), oh(3), oh(3), sl(0, 0, 0, 1, 0));
        applyStimulus("ptr_arb4", 1'b0, oh(4), oh(4), oh(4), rq(-1, -1, -1, -1, 3), A, Z, Z, Z, '0);
        applyStimulus("ptr_g4", 1'b0, oh(4), oh(4), oh(4), rq(-1, -1, -1, -1, 3), A,
                      oh(4), oh(3), oh(3), sl(0, 0, 0, 4, 0));
        applyStimulus("ptr_done", 1'b0, Z, Z, Z, '0, A, Z, Z, Z, '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
